// File: rtl/esop_pkg.sv
// Shared literal encodings and evaluator state type for the ESOP cube evaluator.
package esop_pkg;

    localparam logic [1:0] LIT_DC  = 2'b00;
    localparam logic [1:0] LIT_POS = 2'b01;
    localparam logic [1:0] LIT_NEG = 2'b10;
    localparam logic [1:0] LIT_BAD = 2'b11;

    typedef enum logic [1:0] {LOAD, ARMED, EVAL, RESP} esop_eval_state_t;

endpackage

// File: rtl/esop_cube_match.sv
// Combinational cube match: one product term against an input assignment.
// o_bad flags any invalid literal; such a cube never matches.
module esop_cube_match
    import esop_pkg::*;
#(
    parameter int N_VARS = 10
) (
    input  logic [2*N_VARS-1:0] i_cube,
    input  logic [N_VARS-1:0]   i_x,
    output logic                o_match,
    output logic                o_bad
);

    always_comb begin
        o_match = 1'b1;
        o_bad   = 1'b0;
        for (int i = 0; i < N_VARS; i++) begin
            case (i_cube[2*i +: 2])
                LIT_DC:  ;
                LIT_POS: if (!i_x[i]) o_match = 1'b0;
                LIT_NEG: if (i_x[i])  o_match = 1'b0;
                LIT_BAD: begin
                    o_match = 1'b0;
                    o_bad   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/esop_cube_evaluator.sv
// Stores an ESOP cube list from a valid/ready stream and answers point queries
// f(x) = XOR of cube matches, evaluating one stored cube per cycle.
//
// state | meaning
// LOAD  | accepting cubes into the store
// ARMED | waiting for a query
// EVAL  | folding one stored cube per cycle into the accumulator
// RESP  | presenting the result until consumed
module esop_cube_evaluator
    import esop_pkg::*;
#(
    parameter int N_VARS    = 10,
    parameter int MAX_CUBES = 64
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_clear,
    input  logic                               i_cube_valid,
    output logic                               o_cube_ready,
    input  logic [2*N_VARS-1:0]                i_cube_data,
    input  logic                               i_cube_last,
    input  logic                               i_q_valid,
    output logic                               o_q_ready,
    input  logic [N_VARS-1:0]                  i_q_x,
    output logic                               o_r_valid,
    input  logic                               i_r_ready,
    output logic                               o_r_data,
    output logic [$clog2(MAX_CUBES+1)-1:0]     o_n_cubes,
    output logic                               o_err_lit,
    output logic                               o_err_ovf
);

    localparam int CW = $clog2(MAX_CUBES + 1);
    localparam int IW = (MAX_CUBES > 1) ? $clog2(MAX_CUBES) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CUBES);
    localparam logic [CW-1:0] ONE     = CW'(1);

    esop_eval_state_t    r_state, w_state_nxt;
    logic [CW-1:0]       r_n_cubes, r_idx;
    logic [N_VARS-1:0]   r_x;
    logic                r_acc, r_err_lit, r_err_ovf;
    logic [2*N_VARS-1:0] r_store [MAX_CUBES];

    logic                w_cube_xfer, w_q_xfer, w_match, w_bad, w_store_full_next;
    logic [2*N_VARS-1:0] w_cube_sel;

    // One matcher serves both jobs: literal checking of the incoming beat while
    // loading, and matching the indexed stored cube while evaluating.
    assign w_cube_sel = (r_state == LOAD) ? i_cube_data : r_store[r_idx[IW-1:0]];

    esop_cube_match #(.N_VARS(N_VARS)) u_match (
        .i_cube  (w_cube_sel),
        .i_x     (r_x),
        .o_match (w_match),
        .o_bad   (w_bad)
    );

    assign w_store_full_next = (r_n_cubes == MAX_CNT - ONE);

    always_comb begin
        w_state_nxt  = r_state;
        o_cube_ready = 1'b0;
        o_q_ready    = 1'b0;
        w_cube_xfer  = 1'b0;
        w_q_xfer     = 1'b0;
        if (!i_rst && !i_clear) begin
            case (r_state)
                LOAD: begin
                    o_cube_ready = (r_n_cubes < MAX_CNT);
                    w_cube_xfer  = i_cube_valid && o_cube_ready;
                    if (w_cube_xfer && (i_cube_last || w_store_full_next))
                        w_state_nxt = ARMED;
                end
                ARMED: begin
                    o_q_ready = 1'b1;
                    w_q_xfer  = i_q_valid;
                    if (w_q_xfer)
                        w_state_nxt = (r_n_cubes == '0) ? RESP : EVAL;
                end
                EVAL: begin
                    if (r_idx == r_n_cubes - ONE)
                        w_state_nxt = RESP;
                end
                RESP: begin
                    if (i_r_ready)
                        w_state_nxt = ARMED;
                end
                default: w_state_nxt = LOAD;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_state   <= LOAD;
            r_n_cubes <= '0;
            r_idx     <= '0;
            r_acc     <= 1'b0;
            r_err_lit <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cube_xfer) begin
                r_n_cubes <= r_n_cubes + ONE;
                if (w_bad)
                    r_err_lit <= 1'b1;
                if (!i_cube_last && w_store_full_next)
                    r_err_ovf <= 1'b1;
            end
            if (w_q_xfer) begin
                r_acc <= 1'b0;
                r_idx <= '0;
            end else if (r_state == EVAL) begin
                r_acc <= r_acc ^ w_match;
                r_idx <= r_idx + ONE;
            end
        end
    end

    // Store and query latch carry no reset; n_cubes alone bounds valid entries.
    always_ff @(posedge i_clk) begin
        if (w_cube_xfer)
            r_store[r_n_cubes[IW-1:0]] <= i_cube_data;
        if (w_q_xfer)
            r_x <= i_q_x;
    end

    assign o_r_valid = (r_state == RESP);
    assign o_r_data  = r_acc;
    assign o_n_cubes = r_n_cubes;
    assign o_err_lit = r_err_lit;
    assign o_err_ovf = r_err_ovf;

endmodule

// File: tb/tb_esop_cube_evaluator.sv
// Directed bench for esop_cube_evaluator: stimulus pushes hand-computed results
// into a queue, a negedge monitor pops and checks data, latency and stability.
module tb_esop_cube_evaluator;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_cube_valid = 1'b0;
    logic        i_cube_last = 1'b0;
    logic [19:0] i_cube_data = '0;
    logic        i_q_valid = 1'b0;
    logic [9:0]  i_q_x = '0;
    logic        i_r_ready = 1'b1;
    logic        o_cube_ready, o_q_ready, o_r_valid, o_r_data, o_err_lit, o_err_ovf;
    logic [6:0]  o_n_cubes;

    esop_cube_evaluator #(.N_VARS(10), .MAX_CUBES(64)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (i_clear),
        .i_cube_valid (i_cube_valid),
        .o_cube_ready (o_cube_ready),
        .i_cube_data  (i_cube_data),
        .i_cube_last  (i_cube_last),
        .i_q_valid    (i_q_valid),
        .o_q_ready    (o_q_ready),
        .i_q_x        (i_q_x),
        .o_r_valid    (o_r_valid),
        .i_r_ready    (i_r_ready),
        .o_r_data     (o_r_data),
        .o_n_cubes    (o_n_cubes),
        .o_err_lit    (o_err_lit),
        .o_err_ovf    (o_err_ovf)
    );

    typedef struct {
        logic data;
        int   due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_active = 0;
    bit   mon_orphan = 0;
    logic mon_data;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_cube(input logic [19:0] d, input logic last);
        bit ok;
        ok = 0;
        i_cube_valid = 1'b1;
        i_cube_data  = d;
        i_cube_last  = last;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge i_clk);
            ok = o_cube_ready;
            tick();
        end
        i_cube_valid = 1'b0;
        i_cube_last  = 1'b0;
        if (!ok) chk("cube_accept_timeout", 32'd0, 32'd1);
    endtask

    // Expected response must appear n+1 cycles after the accepting cycle.
    task automatic query(input logic [9:0] x, input logic exp, input int n, input bit push);
        bit ok;
        ok = 0;
        i_q_valid = 1'b1;
        i_q_x     = x;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge i_clk);
            ok = o_q_ready;
            if (ok && push) exp_q.push_back('{exp, cyc + 1 + n});
            tick();
        end
        i_q_valid = 1'b0;
        if (!ok) chk("query_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (exp_q.size() != 0 || o_r_valid); k++) tick();
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    always @(negedge i_clk) begin
        if (i_rst || !o_r_valid) begin
            mon_active = 0;
            mon_orphan = 0;
        end else begin
            if (!mon_active) begin
                mon_active = 1;
                mon_data   = o_r_data;
                if (exp_q.size() == 0) begin
                    mon_orphan = 1;
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    chk("resp_latency", cyc, exp_q[0].due);
                end
            end else begin
                chk("resp_stable", o_r_data, mon_data);
            end
            if (i_r_ready) begin
                if (!mon_orphan) begin
                    mon_e = exp_q.pop_front();
                    chk("resp_data", o_r_data, mon_e.data);
                end
                mon_active = 0;
                mon_orphan = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        repeat (2) begin
            @(negedge i_clk);
            chk("rst_cube_ready", o_cube_ready, 32'd0);
            chk("rst_q_ready", o_q_ready, 32'd0);
        end
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_cube_ready", o_cube_ready, 32'd1);
        chk("post_rst_n_cubes", o_n_cubes, 32'd0);
        chk("post_rst_errs", {o_err_lit, o_err_ovf}, 32'd0);
        chk("post_rst_r_valid", o_r_valid, 32'd0);
        chk("post_rst_r_data", o_r_data, 32'd0);
        chk("post_rst_q_ready", o_q_ready, 32'd0);
        tick();

        // f = x9 ^ (~x3 & ~x4)
        send_cube(20'h40000, 1'b0);
        send_cube(20'h00280, 1'b1);
        @(negedge i_clk);
        chk("t1_n_cubes", o_n_cubes, 32'd2);
        chk("t1_q_ready", o_q_ready, 32'd1);
        chk("t1_cube_ready", o_cube_ready, 32'd0);
        tick();
        query(10'h000, 1'b1, 2, 1);
        query(10'h200, 1'b0, 2, 1);
        query(10'h218, 1'b1, 2, 1);
        drain();

        // constant 1, then the same cube twice cancels
        pulse_clear();
        @(negedge i_clk);
        chk("clr_n_cubes", o_n_cubes, 32'd0);
        chk("clr_cube_ready", o_cube_ready, 32'd1);
        tick();
        send_cube(20'h00000, 1'b1);
        query(10'h3FF, 1'b1, 1, 1);
        drain();
        pulse_clear();
        send_cube(20'h00000, 1'b0);
        send_cube(20'h00000, 1'b1);
        query(10'h3FF, 1'b0, 2, 1);
        drain();

        // overflow: 63 x x0 cubes plus one constant-1 cube, never last
        pulse_clear();
        for (int i = 0; i < 63; i++) send_cube(20'h00001, 1'b0);
        send_cube(20'h00000, 1'b0);
        @(negedge i_clk);
        chk("ovf_err_ovf", o_err_ovf, 32'd1);
        chk("ovf_cube_ready", o_cube_ready, 32'd0);
        chk("ovf_q_ready", o_q_ready, 32'd1);
        chk("ovf_n_cubes", o_n_cubes, 32'd64);
        chk("ovf_err_lit", o_err_lit, 32'd0);
        tick();
        i_cube_valid = 1'b1;
        i_cube_data  = 20'h00000;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("ovf_65th_ready", o_cube_ready, 32'd0);
            tick();
        end
        i_cube_valid = 1'b0;
        chk("ovf_65th_n_cubes", o_n_cubes, 32'd64);
        query(10'h001, 1'b0, 64, 1);
        query(10'h000, 1'b1, 64, 1);
        drain();

        // invalid literal on x0 plus a constant-1 cube
        pulse_clear();
        send_cube(20'h00003, 1'b0);
        send_cube(20'h00000, 1'b1);
        @(negedge i_clk);
        chk("lit_err_lit", o_err_lit, 32'd1);
        chk("lit_err_ovf", o_err_ovf, 32'd0);
        tick();
        query(10'h000, 1'b1, 2, 1);
        query(10'h001, 1'b1, 2, 1);
        drain();
        chk("lit_sticky", o_err_lit, 32'd1);

        // back-pressure on the result with a query waiting
        i_r_ready = 1'b0;
        query(10'h001, 1'b1, 2, 1);
        repeat (2) tick();
        i_q_valid = 1'b1;
        i_q_x     = 10'h000;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("bp_r_valid", o_r_valid, 32'd1);
            chk("bp_q_ready", o_q_ready, 32'd0);
            tick();
        end
        i_r_ready = 1'b1;
        i_q_valid = 1'b0;
        tick();
        drain();

        // clear during EVAL discards the query
        query(10'h000, 1'b1, 2, 0);
        pulse_clear();
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("clr_eval_r_valid", o_r_valid, 32'd0);
            if (k == 0) begin
                chk("clr_eval_n_cubes", o_n_cubes, 32'd0);
                chk("clr_eval_cube_ready", o_cube_ready, 32'd1);
                chk("clr_eval_err_lit", o_err_lit, 32'd0);
            end
            tick();
        end

        // reset during LOAD behaves like clear
        send_cube(20'h00002, 1'b0);
        chk("rst_load_n_before", o_n_cubes, 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_load_cube_ready", o_cube_ready, 32'd0);
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_load_n_cubes", o_n_cubes, 32'd0);
        chk("rst_load_cube_ready_after", o_cube_ready, 32'd1);
        tick();

        // clear with a valid beat: beat must be dropped
        i_clear      = 1'b1;
        i_cube_valid = 1'b1;
        i_cube_data  = 20'h00002;
        i_cube_last  = 1'b1;
        @(negedge i_clk);
        chk("clr_beat_ready", o_cube_ready, 32'd0);
        tick();
        i_clear      = 1'b0;
        i_cube_valid = 1'b0;
        i_cube_last  = 1'b0;
        @(negedge i_clk);
        chk("clr_beat_n_cubes", o_n_cubes, 32'd0);
        tick();
        send_cube(20'h00001, 1'b1);
        query(10'h001, 1'b1, 1, 1);
        query(10'h000, 1'b0, 1, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
